// File: rtl/fetch_unit_pkg.sv
// Shared defaults and helpers for the instruction fetch unit.
package fetch_unit_pkg;

    localparam int unsigned DEF_DATAWIDTH    = 16;
    localparam int unsigned DEF_FETCHQ_DEPTH = 2;

    // Bits needed to hold an occupancy count of 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular fetch queue: {instr, pc} entries, same-cycle push/pop, synchronous clear.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 2 * DEF_DATAWIDTH,
    parameter int unsigned DEPTH = DEF_FETCHQ_DEPTH,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Storage, pointers and occupancy; clear empties the queue in one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (!push && pop) begin
                count <= count - CW'(1);
            end
        end
    end

    // Status and head view.
    always_comb begin
        full  = (count == CW'(DEPTH));
        empty = (count == '0);
        head  = mem[rd_ptr];
    end

    overflow_chk: assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && full && !clear));

    underflow_chk: assert property (@(posedge clk) disable iff (!rst)
        !(pop && empty && !clear));

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: issues imem reads from pc, queues tagged responses, hands them to decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DEF_DATAWIDTH,
    parameter int unsigned DEPTH     = DEF_FETCHQ_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATAWIDTH-1:0] pc,
    input  logic                 flush,
    output logic                 pcEn,
    output logic [DATAWIDTH-1:0] imem_addr,
    output logic                 imem_rd_en,
    input  logic [DATAWIDTH-1:0] imem_rdata,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [DATAWIDTH-1:0] instr,
    output logic [DATAWIDTH-1:0] instr_pc
);

    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned OW = CW + 1;
    localparam int unsigned EW = 2 * DATAWIDTH;

    logic                 inflight;
    logic [DATAWIDTH-1:0] inflight_pc;
    logic [CW-1:0]        count;
    logic                 full;
    logic                 empty;
    logic [EW-1:0]        head;
    logic                 pop;
    logic                 push;
    logic                 issue;
    logic                 room;
    logic [OW-1:0]        occ;

    // Credit check and handshake; every output is gated low while rst is asserted.
    always_comb begin
        instr_valid = rst & !empty & !flush;
        pop         = instr_valid & instr_ready;
        occ         = OW'(count) + OW'(inflight) - OW'(pop);
        room        = (occ < OW'(DEPTH));
        issue       = rst & !flush & room;
        push        = inflight & !flush;
        imem_rd_en  = issue;
        imem_addr   = rst ? pc : '0;
        pcEn        = rst & (issue | flush);
        instr       = rst ? head[EW-1:DATAWIDTH] : '0;
        instr_pc    = rst ? head[DATAWIDTH-1:0]  : '0;
    end

    // Single outstanding read: remember that it exists and where it came from.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .din   ({imem_rdata, inflight_pc}),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  (head)
    );

    // The credit scheme never leaves a read outstanding against a full queue.
    credit_chk: assert property (@(posedge clk) disable iff (!rst) !(full && inflight));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a PC-register model and a 1-cycle instruction memory.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc = 16'h0000;
    logic        flush;
    logic        pcEn;
    logic [15:0] imem_addr;
    logic        imem_rd_en;
    logic [15:0] imem_rdata = 16'h0000;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [15:0] tgt;

    int total = 0;
    int bad   = 0;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .flush       (flush),
        .pcEn        (pcEn),
        .imem_addr   (imem_addr),
        .imem_rd_en  (imem_rd_en),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc)
    );

    always #5 clk = ~clk;

    // Memory: mem[a] = 0xA000 + a, one-cycle read latency.
    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= 16'hA000 + imem_addr;
    end

    // PC block: loads the redirect target on flush, otherwise increments when enabled.
    always @(posedge clk) begin
        if (pcEn) pc <= flush ? tgt : pc + 16'd1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic f, input logic r, input logic [15:0] t);
        @(negedge clk);
        flush       = f;
        instr_ready = r;
        tgt         = t;
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pcEn"},  16'(pcEn),        16'h0);
        chk({tag, "_rden"},  16'(imem_rd_en),  16'h0);
        chk({tag, "_valid"}, 16'(instr_valid), 16'h0);
        chk({tag, "_addr"},  imem_addr,        16'h0);
        chk({tag, "_instr"}, instr,            16'h0);
        chk({tag, "_ipc"},   instr_pc,         16'h0);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; instr_ready = 1'b0; tgt = 16'h0;

        // Reset held for 3 cycles.
        @(negedge clk); #1;
        chk_zero("rst");
        @(negedge clk);
        @(negedge clk);

        // Free run.
        @(negedge clk); rst = 1'b1; instr_ready = 1'b1; #1;
        chk("c0_rden", 16'(imem_rd_en), 16'h1);
        chk("c0_addr", imem_addr, 16'h0000);
        chk("c0_pcEn", 16'(pcEn), 16'h1);
        chk("c0_valid", 16'(instr_valid), 16'h0);
        cyc(1'b0, 1'b1, 16'h0);
        chk("c1_addr", imem_addr, 16'h0001);
        chk("c1_valid", 16'(instr_valid), 16'h0);
        chk("c1_pcEn", 16'(pcEn), 16'h1);
        cyc(1'b0, 1'b1, 16'h0);
        chk("c2_valid", 16'(instr_valid), 16'h1);
        chk("c2_ipc", instr_pc, 16'h0000);
        chk("c2_instr", instr, 16'hA000);
        chk("c2_pcEn", 16'(pcEn), 16'h1);
        cyc(1'b0, 1'b1, 16'h0);
        chk("c3_ipc", instr_pc, 16'h0001);
        chk("c3_instr", instr, 16'hA001);
        chk("c3_pcEn", 16'(pcEn), 16'h1);
        cyc(1'b0, 1'b1, 16'h0);
        chk("c4_ipc", instr_pc, 16'h0002);
        chk("c4_instr", instr, 16'hA002);

        // Decode stall at instr_pc=3: queue fills with 3,4, pc holds at 5.
        cyc(1'b0, 1'b0, 16'h0);
        chk("c5_valid", 16'(instr_valid), 16'h1);
        chk("c5_ipc", instr_pc, 16'h0003);
        chk("c5_pcEn", 16'(pcEn), 16'h0);
        chk("c5_rden", 16'(imem_rd_en), 16'h0);
        chk("c5_addr", imem_addr, 16'h0005);
        cyc(1'b0, 1'b0, 16'h0);
        chk("c6_pcEn", 16'(pcEn), 16'h0);
        chk("c6_ipc", instr_pc, 16'h0003);
        cyc(1'b0, 1'b0, 16'h0);
        chk("c7_pcEn", 16'(pcEn), 16'h0);
        chk("c7_addr", imem_addr, 16'h0005);

        // Queue full, decode ready again: pop and issue in the same cycle.
        cyc(1'b0, 1'b1, 16'h0);
        chk("c8_pcEn", 16'(pcEn), 16'h1);
        chk("c8_rden", 16'(imem_rd_en), 16'h1);
        chk("c8_addr", imem_addr, 16'h0005);
        chk("c8_ipc", instr_pc, 16'h0003);
        chk("c8_instr", instr, 16'hA003);
        cyc(1'b0, 1'b1, 16'h0);
        chk("c9_ipc", instr_pc, 16'h0004);
        chk("c9_instr", instr, 16'hA004);
        chk("c9_addr", imem_addr, 16'h0006);

        // Flush with 5 queued and 6 in flight; redirect to 0x0040.
        cyc(1'b1, 1'b1, 16'h0040);
        chk("c10_valid", 16'(instr_valid), 16'h0);
        chk("c10_rden", 16'(imem_rd_en), 16'h0);
        chk("c10_pcEn", 16'(pcEn), 16'h1);
        cyc(1'b0, 1'b1, 16'h0);
        chk("c11_valid", 16'(instr_valid), 16'h0);
        chk("c11_addr", imem_addr, 16'h0040);
        chk("c11_rden", 16'(imem_rd_en), 16'h1);
        cyc(1'b0, 1'b1, 16'h0);
        chk("c12_valid", 16'(instr_valid), 16'h0);
        cyc(1'b0, 1'b1, 16'h0);
        chk("c13_valid", 16'(instr_valid), 16'h1);
        chk("c13_ipc", instr_pc, 16'h0040);
        chk("c13_instr", instr, 16'hA040);

        // Back-to-back flush: 0x0010 then 0x0020.
        cyc(1'b1, 1'b1, 16'h0010);
        chk("c14_rden", 16'(imem_rd_en), 16'h0);
        chk("c14_pcEn", 16'(pcEn), 16'h1);
        chk("c14_valid", 16'(instr_valid), 16'h0);
        cyc(1'b1, 1'b1, 16'h0020);
        chk("c15_rden", 16'(imem_rd_en), 16'h0);
        chk("c15_pcEn", 16'(pcEn), 16'h1);
        chk("c15_valid", 16'(instr_valid), 16'h0);
        chk("c15_addr", imem_addr, 16'h0010);
        cyc(1'b0, 1'b1, 16'h0);
        chk("c16_addr", imem_addr, 16'h0020);
        chk("c16_valid", 16'(instr_valid), 16'h0);
        cyc(1'b0, 1'b1, 16'h0);
        chk("c17_valid", 16'(instr_valid), 16'h0);
        cyc(1'b0, 1'b1, 16'h0);
        chk("c18_valid", 16'(instr_valid), 16'h1);
        chk("c18_ipc", instr_pc, 16'h0020);
        chk("c18_instr", instr, 16'hA020);

        // Reset mid-operation: 0x21 queued, 0x22 in flight, pc at 0x23.
        cyc(1'b0, 1'b0, 16'h0);
        chk("c19_ipc", instr_pc, 16'h0021);
        chk("c19_pcEn", 16'(pcEn), 16'h0);
        #1 rst = 1'b0;
        #1;
        chk_zero("arst");
        @(negedge clk);
        @(negedge clk); #1;
        chk_zero("arst_hold");
        @(negedge clk); rst = 1'b1; instr_ready = 1'b1; #1;
        chk("r0_rden", 16'(imem_rd_en), 16'h1);
        chk("r0_addr", imem_addr, 16'h0023);
        chk("r0_valid", 16'(instr_valid), 16'h0);
        cyc(1'b0, 1'b1, 16'h0);
        chk("r1_valid", 16'(instr_valid), 16'h0);
        chk("r1_addr", imem_addr, 16'h0024);
        cyc(1'b0, 1'b1, 16'h0);
        chk("r2_valid", 16'(instr_valid), 16'h1);
        chk("r2_ipc", instr_pc, 16'h0023);
        chk("r2_instr", instr, 16'hA023);
        cyc(1'b0, 1'b1, 16'h0);
        chk("r3_ipc", instr_pc, 16'h0024);
        chk("r3_instr", instr, 16'hA024);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
